// File: rtl/mul_accumulator.sv
// Multiply-accumulate back end: sums a programmed number of products into a
// guard-extended, saturating accumulator and presents it on a valid/ready port.
module mul_accumulator #(
    parameter int W = 16,
    parameter int G = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [7:0]     len,
    input  logic           k,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+G-1:0] acc,
    output logic           ovf,
    output logic           busy
);

    localparam int AW = W + G;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic [7:0]  len_r;
    logic        k_r;
    logic        take;
    logic        sat;
    logic [AW:0] y_ext;
    logic [AW:0] acc_ext;
    logic [AW:0] sum;
    logic [AW-1:0] acc_step;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // One extra bit beyond AW holds the carry/sign needed to detect a clamp.
    always_comb begin
        state_next = state;
        take       = (state == ACC) && in_valid;
        cnt_inc    = cnt + 8'd1;
        y_ext      = k_r ? {{(AW + 1 - W){y[W-1]}}, y} : {{(AW + 1 - W){1'b0}}, y};
        acc_ext    = k_r ? {acc[AW-1], acc} : {1'b0, acc};
        sum        = acc_ext + y_ext;
        sat        = 1'b0;
        acc_step   = sum[AW-1:0];
        if (k_r) begin
            if (sum[AW] != sum[AW-1]) begin
                sat      = 1'b1;
                acc_step = sum[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
            end
        end else if (sum[AW]) begin
            sat      = 1'b1;
            acc_step = {AW{1'b1}};
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == 8'd0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (take && (cnt_inc == len_r)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The result stays on acc after DONE until a new job is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= 8'd0;
            len_r <= 8'd0;
            k_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= 8'd0;
                        len_r <= len;
                        k_r   <= k;
                    end
                end
                ACC: begin
                    if (take) begin
                        acc <= acc_step;
                        ovf <= ovf | sat;
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed, self-checking bench for mul_accumulator with hand-computed
// expected sums, saturation, backpressure, zero-length jobs and mid-job reset.
module tb_mul_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        k;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] acc;
    logic        ovf;
    logic        busy;

    int checks;
    int passed;

    mul_accumulator #(.W(16), .G(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .k        (k),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc      (acc),
        .ovf      (ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge take them, then settle for sampling.
    task automatic applyStimulus(input logic s, input logic [7:0] l, input logic kk,
                                 input logic iv, input logic [15:0] yy, input logic ordy);
        start     = s;
        len       = l;
        k         = kk;
        in_valid  = iv;
        y         = yy;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        k         = 1'b0;
        in_valid  = 1'b0;
        y         = 16'd0;
        out_ready = 1'b0;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 16'h1234, 1);
        checkOutput("rst_acc", acc, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 16'd99, 0);
        checkOutput("idle_ignores_y", acc, 0);

        // Unsigned sum 100+200+300
        $display("[TB] unsigned sum");
        applyStimulus(1, 3, 0, 0, 0, 0);
        checkOutput("u_busy", busy, 1);
        checkOutput("u_in_ready", in_ready, 1);
        applyStimulus(0, 0, 1, 1, 16'd100, 0);
        checkOutput("u_acc1", acc, 100);
        applyStimulus(0, 0, 1, 1, 16'd200, 0);
        checkOutput("u_acc2", acc, 300);
        checkOutput("u_not_done", out_valid, 0);
        applyStimulus(0, 0, 1, 1, 16'd300, 0);
        checkOutput("u_acc3", acc, 600);
        checkOutput("u_out_valid", out_valid, 1);
        checkOutput("u_in_ready_low", in_ready, 0);
        checkOutput("u_ovf", ovf, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("u_idle_valid", out_valid, 0);
        checkOutput("u_idle_busy", busy, 0);
        checkOutput("u_acc_kept", acc, 600);

        // Signed sum with idle gaps: -6 + 10 - 20 = -16
        $display("[TB] signed sum with gaps");
        applyStimulus(1, 3, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 16'hFFFA, 0);
        checkOutput("s_acc1", acc, 32'hFFFFA);
        applyStimulus(0, 0, 0, 0, 16'h5555, 0);
        checkOutput("s_gap_hold", acc, 32'hFFFFA);
        checkOutput("s_gap_ready", in_ready, 1);
        applyStimulus(0, 0, 0, 1, 16'd10, 0);
        checkOutput("s_acc2", acc, 32'h00004);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 16'hFFEC, 0);
        checkOutput("s_acc3", acc, 32'hFFFF0);
        checkOutput("s_ovf", ovf, 0);
        checkOutput("s_out_valid", out_valid, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Signed saturation: 16*0x7FFF fits, the 17th clamps
        $display("[TB] signed saturation");
        applyStimulus(1, 17, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1, 16'h7FFF, 0);
        checkOutput("ss_acc16", acc, 32'h7FFF0);
        checkOutput("ss_ovf16", ovf, 0);
        applyStimulus(0, 0, 0, 1, 16'h7FFF, 0);
        checkOutput("ss_acc", acc, 32'h7FFFF);
        checkOutput("ss_ovf", ovf, 1);
        checkOutput("ss_out_valid", out_valid, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Unsigned saturation: 16*0xFFFF fits, the 17th clamps
        $display("[TB] unsigned saturation");
        applyStimulus(1, 17, 0, 0, 0, 0);
        checkOutput("us_ovf_cleared", ovf, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 1, 16'hFFFF, 0);
        checkOutput("us_acc16", acc, 32'hFFFF0);
        applyStimulus(0, 0, 1, 1, 16'hFFFF, 0);
        checkOutput("us_acc", acc, 32'hFFFFF);
        checkOutput("us_ovf", ovf, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Backpressure: result held while start/in_valid pulse
        $display("[TB] output backpressure");
        applyStimulus(1, 2, 0, 0, 0, 0);
        checkOutput("bp_acc_cleared", acc, 0);
        checkOutput("bp_ovf_cleared", ovf, 0);
        applyStimulus(0, 0, 0, 1, 16'd5, 0);
        applyStimulus(0, 0, 0, 1, 16'd9, 0);
        checkOutput("bp_acc", acc, 14);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 3, 1, 1, 16'd1000, 0);
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_hold_acc", acc, 14);
        end
        checkOutput("bp_no_ready", in_ready, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("bp_released", out_valid, 0);
        checkOutput("bp_busy", busy, 0);

        // Zero-length job started right after the previous one returns to IDLE
        $display("[TB] zero-length job");
        applyStimulus(1, 0, 1, 1, 16'd77, 0);
        checkOutput("z_out_valid", out_valid, 1);
        checkOutput("z_acc", acc, 0);
        checkOutput("z_ovf", ovf, 0);
        checkOutput("z_in_ready", in_ready, 0);
        applyStimulus(0, 0, 0, 1, 16'd77, 1);
        checkOutput("z_acc_after", acc, 0);
        checkOutput("z_idle", busy, 0);

        // Reset mid-job discards the partial sum
        $display("[TB] reset mid-job");
        applyStimulus(1, 5, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 16'd3, 0);
        applyStimulus(0, 0, 0, 1, 16'd4, 0);
        checkOutput("r_partial", acc, 7);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 1, 16'd50, 0);
        checkOutput("r_acc", acc, 0);
        checkOutput("r_busy", busy, 0);
        checkOutput("r_in_ready", in_ready, 0);
        checkOutput("r_out_valid", out_valid, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 16'd7, 0);
        checkOutput("r_new_acc", acc, 7);
        checkOutput("r_new_valid", out_valid, 1);
        checkOutput("r_new_ovf", ovf, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
